// File: rtl/cic_pkg.sv
// Shared constants, types and the output scaling helper for the CIC interpolator
// and decimator datapaths.
package cic_pkg;

  localparam int unsigned IN_W     = 16;
  localparam int unsigned ACC_W    = 40;
  localparam int unsigned N_STAGES = 4;
  localparam int unsigned SHIFT_W  = 6;
  localparam int unsigned RATIO_W  = 16;

  typedef logic signed [ACC_W-1:0] acc_t;
  typedef logic signed [IN_W-1:0]  sample_t;

  localparam acc_t SatMax = acc_t'(2 ** (IN_W - 1) - 1);
  localparam acc_t SatMin = acc_t'(-(2 ** (IN_W - 1)));

  // Arithmetic right shift of a wide accumulator, then clamp to the sample range.
  function automatic sample_t sat_shift(acc_t acc, logic [SHIFT_W-1:0] shift);
    acc_t shifted;
    shifted = acc >>> shift;
    if (shifted > SatMax) begin
      return sample_t'(SatMax);
    end else if (shifted < SatMin) begin
      return sample_t'(SatMin);
    end else begin
      return sample_t'(shifted);
    end
  endfunction

endpackage

// File: rtl/cic_out_scale.sv
// Registered shift-and-saturate stage; updates only when en_i is high, with a
// one-cycle valid pulse per enable.
module cic_out_scale
  import cic_pkg::*;
(
  input  logic                    aclk,
  input  logic                    reset,
  input  logic                    en_i,
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [SHIFT_W-1:0]      shift_i,
  output logic signed [IN_W-1:0]  out_o,
  output logic                    valid_o
);

  sample_t out_q, out_d;
  logic    valid_q, valid_d;

  // Next output: scaled accumulator on enable, otherwise hold the last sample.
  always_comb begin
    out_d   = out_q;
    valid_d = en_i;
    if (en_i) begin
      out_d = sat_shift(acc_i, shift_i);
    end
  end

  // Output register with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out_o   = out_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/cic_interp.sv
// Four-stage CIC interpolator: one-entry input holding register, low-rate comb
// chain evaluated once per frame, zero-stuffing by a runtime ratio and a
// high-rate integrator chain advanced on each out_en tick.
module cic_interp
  import cic_pkg::*;
(
  input  logic                   aclk,
  input  logic                   reset,
  input  logic signed [IN_W-1:0] in_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [RATIO_W-1:0]     interp_ratio_i,
  input  logic [SHIFT_W-1:0]     out_shift_i,
  input  logic                   out_en_i,
  output logic signed [IN_W-1:0] out_o,
  output logic                   out_valid_o,
  output logic                   underrun_o
);

  sample_t            hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               underrun_q, underrun_d;
  logic [RATIO_W-1:0] ratio_q, ratio_d;
  logic [RATIO_W-1:0] phase_q, phase_d;
  acc_t               dly_q [N_STAGES];
  acc_t               dly_d [N_STAGES];
  acc_t               integ_q [N_STAGES];
  acc_t               integ_d [N_STAGES];
  acc_t               comb_res_q, comb_res_d;

  logic frame_end;
  logic load;
  logic xfer;

  assign in_ready_o = ~hold_full_q & ~reset;
  assign xfer       = in_valid_i & in_ready_o;
  assign frame_end  = (phase_q == ratio_q - RATIO_W'(1));
  assign load       = out_en_i & frame_end;

  // Next state: comb load at frame end, integrators and phase on every tick,
  // holding register fill on handshake.
  always_comb begin
    acc_t diff;

    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;
    ratio_d     = ratio_q;
    phase_d     = phase_q;
    dly_d       = dly_q;
    integ_d     = integ_q;
    comb_res_d  = comb_res_q;

    // An empty holding register stuffs zero into the comb chain.
    diff = hold_full_q ? acc_t'(hold_q) : '0;

    if (load) begin
      for (int unsigned i = 0; i < N_STAGES; i++) begin
        dly_d[i] = diff;
        diff     = diff - dly_q[i];
      end
      comb_res_d  = diff;
      hold_full_d = 1'b0;
      if (!hold_full_q) begin
        underrun_d = 1'b1;
      end
      // Ratio only changes on a frame boundary so a frame never gets cut short.
      ratio_d = (interp_ratio_i == '0) ? RATIO_W'(1) : interp_ratio_i;
    end

    if (out_en_i) begin
      phase_d    = frame_end ? '0 : phase_q + RATIO_W'(1);
      // Comb result enters only at phase 0; the rest of the frame is zero-stuffed.
      integ_d[0] = integ_q[0] + ((phase_q == '0) ? comb_res_q : '0);
      for (int unsigned i = 1; i < N_STAGES; i++) begin
        integ_d[i] = integ_q[i] + integ_q[i-1];
      end
    end

    // A transfer landing on a load cycle is held for the next frame.
    if (xfer) begin
      hold_d      = in_i;
      hold_full_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (reset) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
      ratio_q     <= RATIO_W'(1);
      phase_q     <= '0;
      comb_res_q  <= '0;
      for (int unsigned i = 0; i < N_STAGES; i++) begin
        dly_q[i]   <= '0;
        integ_q[i] <= '0;
      end
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      ratio_q     <= ratio_d;
      phase_q     <= phase_d;
      comb_res_q  <= comb_res_d;
      dly_q       <= dly_d;
      integ_q     <= integ_d;
    end
  end

  // Output uses the last integrator's value from before this tick's update.
  cic_out_scale u_out_scale (
    .aclk    (aclk),
    .reset   (reset),
    .en_i    (out_en_i),
    .acc_i   (integ_q[N_STAGES-1]),
    .shift_i (out_shift_i),
    .out_o   (out_o),
    .valid_o (out_valid_o)
  );

  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_cic_interp.sv
// Bench for cic_interp. The reference model describes the filter in closed form:
// each frame's comb output is the 4th difference of the loaded samples, injected
// at its frame's phase-0 tick, and four cascaded running sums of an impulse
// injected at tick t contribute C(n-1-t, 3) to the output registered at tick n.
module tb_cic_interp;

  logic               aclk         = 1'b0;
  logic               reset        = 1'b1;
  logic signed [15:0] in_s         = '0;
  logic               in_valid     = 1'b0;
  logic               in_ready;
  logic [15:0]        interp_ratio = 16'd1;
  logic [5:0]         out_shift    = '0;
  logic               out_en       = 1'b0;
  logic signed [15:0] out_s;
  logic               out_valid;
  logic               underrun;

  always #5 aclk = ~aclk;

  cic_interp u_dut (
    .aclk           (aclk),
    .reset          (reset),
    .in_i           (in_s),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .interp_ratio_i (interp_ratio),
    .out_shift_i    (out_shift),
    .out_en_i       (out_en),
    .out_o          (out_s),
    .out_valid_o    (out_valid),
    .underrun_o     (underrun)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  bit     m_full;
  longint m_hold;
  longint m_p;
  longint m_ratio = 1;
  bit     m_under;
  longint m_nt;
  longint m_x[$];
  longint m_c[$];
  longint m_t[$];
  longint m_out;
  bit     m_ovalid;

  // Producer and observation state.
  longint src[$];
  longint fill_val   = 0;
  bit     fill_rand  = 1'b0;
  bit     prod_on    = 1'b0;
  int     valid_pct  = 100;
  bit     prev_ready = 1'b0;
  longint load_ticks[$];

  typedef struct {
    int     tick;
    longint exp_out;
  } imp_vec_t;

  typedef struct {
    int     ratio;
    int     shift;
    longint din;
    longint exp_out;
  } dc_vec_t;

  imp_vec_t imp_tab[17];
  dc_vec_t  dc_tab[7];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint binom3(longint m);
    if (m < 3) return 0;
    return m * (m - 1) * (m - 2) / 6;
  endfunction

  function automatic longint model_acc(longint nt);
    longint s;
    s = 0;
    for (int k = 0; k < m_c.size(); k++) s += m_c[k] * binom3(nt - 1 - m_t[k]);
    return s;
  endfunction

  function automatic longint sat16(longint v, int sh);
    longint s;
    s = v >>> sh;
    if (s > 32767) return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  // Advance the model over one clock edge using the inputs applied before it.
  task automatic model_edge(output bit xfer);
    longint x;
    longint c;
    longint coef[5];
    int     sz;
    coef = '{1, -4, 6, -4, 1};
    xfer = 1'b0;
    if (reset) begin
      m_full = 1'b0; m_hold = 0; m_p = 0; m_ratio = 1; m_under = 1'b0; m_nt = 0;
      m_x.delete(); m_c.delete(); m_t.delete(); m_out = 0; m_ovalid = 1'b0;
      return;
    end
    xfer = in_valid && !m_full;
    if (out_en) begin
      m_out    = sat16(model_acc(m_nt), int'(out_shift));
      m_ovalid = 1'b1;
      if (m_p == m_ratio - 1) begin
        x = m_full ? m_hold : 0;
        if (!m_full) m_under = 1'b1;
        m_x.push_back(x);
        sz = m_x.size();
        c  = 0;
        for (int j = 0; j < 5; j++) if (sz - 1 - j >= 0) c += coef[j] * m_x[sz - 1 - j];
        m_c.push_back(c);
        m_t.push_back(m_nt + 1);
        m_full  = 1'b0;
        m_ratio = (interp_ratio == 16'd0) ? 1 : longint'(interp_ratio);
        m_p     = 0;
      end else begin
        m_p++;
      end
      m_nt++;
    end else begin
      m_ovalid = 1'b0;
    end
    if (xfer) begin
      m_full = 1'b1;
      m_hold = longint'(in_s);
    end
  endtask

  task automatic cycle(input bit tick);
    bit xfer;
    out_en = tick;
    if (prod_on && (int'($urandom_range(99)) < valid_pct)) begin
      in_valid = 1'b1;
      if (src.size() > 0)  in_s = 16'(src[0]);
      else if (fill_rand)  in_s = 16'($urandom);
      else                 in_s = 16'(fill_val);
    end else begin
      in_valid = 1'b0;
      in_s     = 16'($urandom);
    end
    @(posedge aclk);
    model_edge(xfer);
    if (xfer && src.size() > 0) void'(src.pop_front());
    #1;
    check("out", out_s, m_out);
    check("out_valid", out_valid, m_ovalid);
    check("in_ready", in_ready, !m_full && !reset);
    check("underrun", underrun, m_under);
    if (in_ready && !prev_ready) load_ticks.push_back(m_nt);
    prev_ready = in_ready;
  endtask

  task automatic ticks(input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      repeat (gap - 1) cycle(1'b0);
      cycle(1'b1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0);
    cycle(1'b0);
    reset = 1'b0;
    #1;
    check("in_ready_after_reset", in_ready, 1);
    check("out_after_reset", out_s, 0);
    check("out_valid_after_reset", out_valid, 0);
    load_ticks.delete();
  endtask

  task automatic run_impulse(input string tag);
    longint got[$];
    interp_ratio = 16'd4;
    out_shift    = 6'd0;
    src.delete();
    src.push_back(1);
    fill_val  = 0;
    fill_rand = 1'b0;
    prod_on   = 1'b1;
    valid_pct = 100;
    do_reset();
    for (int i = 0; i < 21; i++) begin
      ticks(1, 3);
      got.push_back(longint'(out_s));
    end
    for (int i = 0; i < 17; i++)
      check($sformatf("%s_tick%0d", tag, imp_tab[i].tick), got[imp_tab[i].tick],
            imp_tab[i].exp_out);
  endtask

  initial begin
    int     rs[7];
    longint lprev;
    longint imp_exp[17];

    imp_exp = '{0, 0, 1, 4, 10, 20, 31, 40, 44, 40, 31, 20, 10, 4, 1, 0, 0};
    for (int i = 0; i < 17; i++) imp_tab[i] = '{i + 3, imp_exp[i]};
    dc_tab[0] = '{4, 6, 100, 100};
    dc_tab[1] = '{8, 9, 1234, 1234};
    dc_tab[2] = '{2, 3, -500, -500};
    dc_tab[3] = '{1, 0, 77, 77};
    dc_tab[4] = '{64, 0, 32767, 32767};
    dc_tab[5] = '{64, 0, -32768, -32768};
    dc_tab[6] = '{64, 18, -20000, -20000};
    rs = '{1, 2, 3, 4, 5, 8, 16};

    // DC response and saturation, steady-state value from the table.
    for (int v = 0; v < 7; v++) begin
      interp_ratio = 16'(dc_tab[v].ratio);
      out_shift    = 6'(dc_tab[v].shift);
      src.delete();
      fill_val  = dc_tab[v].din;
      fill_rand = 1'b0;
      prod_on   = 1'b1;
      valid_pct = 100;
      do_reset();
      ticks(6 * dc_tab[v].ratio + 20, 3);
      check($sformatf("dc%0d_out", v), out_s, dc_tab[v].exp_out);
      check($sformatf("dc%0d_underrun", v), underrun, 0);
    end

    // Impulse response from a clean reset.
    run_impulse("impulse");

    // Underrun: producer stops mid-stream, flag is sticky, reset clears it.
    interp_ratio = 16'd2;
    out_shift    = 6'd3;
    src.delete();
    fill_rand = 1'b1;
    prod_on   = 1'b1;
    valid_pct = 100;
    do_reset();
    ticks(20, 3);
    check("underrun_before_starve", underrun, 0);
    prod_on = 1'b0;
    ticks(30, 3);
    check("underrun_after_starve", underrun, 1);
    do_reset();
    check("underrun_cleared", underrun, 0);

    // Transfer coinciding with a load on an empty hold is not used by that load.
    interp_ratio = 16'd1;
    prod_on      = 1'b0;
    do_reset();
    cycle(1'b0);
    src.delete();
    src.push_back(555);
    fill_rand = 1'b0;
    fill_val  = 0;
    prod_on   = 1'b1;
    cycle(1'b1);
    check("coincide_underrun", underrun, 1);
    check("coincide_hold_full", in_ready, 0);
    ticks(8, 3);

    // Ratio change 4 -> 8 at p=1, then ratio 0 acting as 1.
    interp_ratio = 16'd4;
    out_shift    = 6'd6;
    src.delete();
    fill_rand = 1'b1;
    prod_on   = 1'b1;
    valid_pct = 100;
    do_reset();
    ticks(12, 3);
    for (int i = 0; i < 8 && m_p != 1; i++) ticks(1, 3);
    check("ratio_change_sync_p", m_p, 1);
    check("ratio_loads_seen", load_ticks.size() > 0, 1);
    lprev = (load_ticks.size() > 0) ? load_ticks[$] : 0;
    interp_ratio = 16'd8;
    load_ticks.delete();
    ticks(20, 3);
    check("ratio_loads_after", load_ticks.size() >= 3, 1);
    if (load_ticks.size() >= 3) begin
      check("ratio_frame_old", load_ticks[0] - lprev, 4);
      check("ratio_frame_new1", load_ticks[1] - load_ticks[0], 8);
      check("ratio_frame_new2", load_ticks[2] - load_ticks[1], 8);
    end
    interp_ratio = 16'd0;
    ticks(10, 3);
    load_ticks.delete();
    ticks(6, 3);
    check("ratio0_loads", load_ticks.size() >= 5, 1);
    if (load_ticks.size() >= 5)
      for (int i = 1; i < 5; i++)
        check($sformatf("ratio0_gap%0d", i), load_ticks[i] - load_ticks[i-1], 1);

    // Reset mid-stream with hold full and live integrators, then impulse again.
    interp_ratio = 16'd4;
    out_shift    = 6'd0;
    src.delete();
    fill_rand = 1'b1;
    prod_on   = 1'b1;
    valid_pct = 100;
    do_reset();
    ticks(20, 3);
    for (int i = 0; i < 4 && !m_full; i++) cycle(1'b0);
    check("midstream_hold_full", in_ready, 0);
    run_impulse("impulse_after_reset");

    // Randomized segments: ratio, shift, producer rate and tick spacing all vary.
    for (int seg = 0; seg < 6; seg++) begin
      interp_ratio = 16'(rs[$urandom_range(6)]);
      out_shift    = 6'($urandom_range(16));
      src.delete();
      fill_rand = 1'b1;
      prod_on   = 1'b1;
      valid_pct = int'($urandom_range(100, 60));
      do_reset();
      for (int t = 0; t < 150; t++) begin
        if ($urandom_range(19) == 0) interp_ratio = 16'(rs[$urandom_range(6)]);
        if ($urandom_range(29) == 0) out_shift = 6'($urandom_range(16));
        ticks(1, int'($urandom_range(4, 1)));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
             checks, failures);
    $fatal(1, "timeout");
  end

endmodule
